// File: rtl/btn_tick_ctrl.sv
// Front end for the alarm-clock datapath: divides the system clock into a
// one-cycle seconds tick and conditions the raw buttons into synchronized,
// debounced levels plus one-cycle advance strobes with optional auto-repeat.
module btn_tick_ctrl #(
  parameter int             NB        = 8,
  parameter int             TICK_DIV  = 50000000,
  parameter int             DB_CYCLES = 1000000,
  parameter int             REP_DLY   = 25000000,
  parameter int             REP_PER   = 12500000,
  parameter logic [NB-1:0]  REP_EN    = 8'b0111_1100
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NB-1:0] btn_raw,
  input  logic          tick_clr,
  output logic          pulse,
  output logic [NB-1:0] level,
  output logic [NB-1:0] adv
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;
  localparam int RW = $clog2(REP_DLY + 1);

  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] REP_TOP    = RW'(REP_DLY);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REP_DLY - REP_PER);

  logic [PW-1:0]         cnt_q, cnt_d;
  logic                  pulse_q, pulse_d;
  logic [NB-1:0]         s1_q, s1_d;
  logic [NB-1:0]         s2_q, s2_d;
  logic [NB-1:0]         level_q, level_d;
  logic [NB-1:0][DW-1:0] dbc_q, dbc_d;
  logic [NB-1:0][RW-1:0] rc_q, rc_d;
  logic [NB-1:0]         adv_q, adv_d;

  // Prescaler: the tick is raised on the edge where the counter wraps out of
  // its last value; tick_clr re-phases the seconds and suppresses the tick.
  always_comb begin
    cnt_d   = cnt_q + PW'(1);
    pulse_d = (cnt_q == TICK_LAST);
    if (cnt_q == TICK_LAST) begin
      cnt_d = '0;
    end
    if (tick_clr) begin
      cnt_d   = '0;
      pulse_d = 1'b0;
    end
  end

  // Two-flop synchronizer for the asynchronous button levels.
  always_comb begin
    s1_d = btn_raw;
    s2_d = s1_q;
  end

  // Debounce: a level change is accepted only after the synchronized input
  // has disagreed with the current level for DB_CYCLES consecutive edges.
  always_comb begin
    level_d = level_q;
    dbc_d   = dbc_q;
    for (int i = 0; i < NB; i++) begin
      if (s2_q[i] == level_q[i]) begin
        dbc_d[i] = '0;
      end else if (dbc_q[i] == DB_LAST) begin
        level_d[i] = s2_q[i];
        dbc_d[i]   = '0;
      end else begin
        dbc_d[i] = dbc_q[i] + DW'(1);
      end
    end
  end

  // Advance strobes: one on each accepted press, then auto-repeat while held
  // for the enabled bits. The repeat counter never holds REP_TOP; reaching it
  // fires the strobe and reloads so later strobes come every REP_PER cycles.
  always_comb begin
    logic [RW-1:0] rc_inc;
    rc_inc = '0;
    rc_d   = '0;
    adv_d  = '0;
    for (int i = 0; i < NB; i++) begin
      rc_inc = rc_q[i] + RW'(1);
      if (level_d[i] && !level_q[i]) begin
        adv_d[i] = 1'b1;
      end else if (level_d[i] && level_q[i] && REP_EN[i]) begin
        if (rc_inc == REP_TOP) begin
          adv_d[i] = 1'b1;
          rc_d[i]  = REP_RELOAD;
        end else begin
          rc_d[i] = rc_inc;
        end
      end
    end
  end

  // State registers; reset clears everything on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      dbc_q   <= '0;
      rc_q    <= '0;
      adv_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      dbc_q   <= dbc_d;
      rc_q    <= rc_d;
      adv_q   <= adv_d;
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;
  assign adv   = adv_q;

endmodule
